rv_ctl: RTL and testbench

Multicycle control FSM for the 32-bit RISC-V datapath. Decodes the latched instruction and drives every datapath control strobe, one state per cycle. Supports the RV32I subset of OP, OP-IMM except SRAI, LOAD (LW), STORE (SW), BRANCH, JAL and JALR. Handshakes with instruction and data memories through ready inputs, and reports retirement and illegal instructions.

---
 rtl/rv_ctl.sv | 264 ++++++++++++++++++++++++++
 tb/tb_rv_ctl.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_ctl.sv
// Multicycle control FSM for the RV32I datapath: decodes the latched IR and
// drives every datapath strobe, one state per cycle, with memory ready handshakes.
module rv_ctl #(
    parameter int DPWIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [DPWIDTH-1:0] instr,
    input  logic               zero,
    input  logic               imem_ready,
    input  logic               dmem_ready,
    output logic               pcsourse,
    output logic               pcwrite,
    output logic               pccen,
    output logic               irwrite,
    output logic               regwen,
    output logic               mdrwrite,
    output logic [1:0]         wbsel,
    output logic [1:0]         immsel,
    output logic [1:0]         asel,
    output logic [1:0]         bsel,
    output logic [3:0]         alusel,
    output logic               dmem_re,
    output logic               dmem_we,
    output logic               retire,
    output logic               illegal
);

    typedef enum logic [3:0] {
        ST_RST     = 4'd0,
        ST_FETCH   = 4'd1,
        ST_DECODE  = 4'd2,
        ST_EXEC_R  = 4'd3,
        ST_EXEC_I  = 4'd4,
        ST_WB_ALU  = 4'd5,
        ST_ADDR    = 4'd6,
        ST_MEM_RD  = 4'd7,
        ST_WB_MEM  = 4'd8,
        ST_MEM_WR  = 4'd9,
        ST_BR_CMP  = 4'd10,
        ST_BR_TGT  = 4'd11,
        ST_JMP_TGT = 4'd12,
        ST_PC_JMP  = 4'd13,
        ST_TRAP    = 4'd14
    } state_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;

    localparam logic [1:0] WB_MDR    = 2'd0;
    localparam logic [1:0] WB_ALUOUT = 2'd1;
    localparam logic [1:0] WB_PC     = 2'd2;
    localparam logic [1:0] IMM_J     = 2'd0;
    localparam logic [1:0] IMM_B     = 2'd1;
    localparam logic [1:0] IMM_S     = 2'd2;
    localparam logic [1:0] IMM_L     = 2'd3;
    localparam logic [1:0] A_REG     = 2'd0;
    localparam logic [1:0] A_PCC     = 2'd1;
    localparam logic [1:0] B_REG     = 2'd0;
    localparam logic [1:0] B_IMM     = 2'd1;

    state_t     state_r;
    logic [6:0] opcode_s;
    logic [2:0] funct3_s;
    logic       funct7b5_s;
    logic       is_store_s;
    logic       unused_s;

    assign opcode_s   = instr[6:0];
    assign funct3_s   = instr[14:12];
    assign funct7b5_s = instr[30];
    assign is_store_s = (opcode_s == OPC_STORE);
    assign unused_s   = ^{instr[DPWIDTH-1:31], instr[29:15], instr[11:7]};

    function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  alu_op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  alu_op = ALU_SLL;
            3'b010:  alu_op = ALU_SLT;
            3'b011:  alu_op = ALU_SLTU;
            3'b100:  alu_op = ALU_XOR;
            3'b101:  alu_op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  alu_op = ALU_OR;
            3'b111:  alu_op = ALU_AND;
            default: alu_op = ALU_ADD;
        endcase
    endfunction

    function automatic logic [3:0] branch_alu(input logic [2:0] f3);
        case (f3[2:1])
            2'b00:   branch_alu = ALU_SUB;
            2'b10:   branch_alu = ALU_SLT;
            2'b11:   branch_alu = ALU_SLTU;
            default: branch_alu = ALU_SUB;
        endcase
    endfunction

    // BEQ/BGE/BGEU take on a zero compare result; BNE/BLT/BLTU on non-zero.
    function automatic logic branch_taken(input logic [2:0] f3, input logic z);
        case (f3)
            3'b000:  branch_taken = z;
            3'b001:  branch_taken = ~z;
            3'b100:  branch_taken = ~z;
            3'b101:  branch_taken = z;
            3'b110:  branch_taken = ~z;
            3'b111:  branch_taken = z;
            default: branch_taken = 1'b0;
        endcase
    endfunction

    function automatic state_t dispatch(input logic [6:0] opc, input logic [2:0] f3,
                                        input logic alt);
        case (opc)
            OPC_OP:     dispatch = ST_EXEC_R;
            OPC_OP_IMM: dispatch = (f3 == 3'b101 && alt) ? ST_TRAP : ST_EXEC_I;
            OPC_LOAD:   dispatch = (f3 == 3'b010) ? ST_ADDR : ST_TRAP;
            OPC_STORE:  dispatch = (f3 == 3'b010) ? ST_ADDR : ST_TRAP;
            OPC_BRANCH: dispatch = (f3[2:1] == 2'b01) ? ST_TRAP : ST_BR_CMP;
            OPC_JAL:    dispatch = ST_JMP_TGT;
            OPC_JALR:   dispatch = (f3 == 3'b000) ? ST_JMP_TGT : ST_TRAP;
            default:    dispatch = ST_TRAP;
        endcase
    endfunction

    // State register and transition logic; TRAP is only left through rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_RST;
        end else begin
            case (state_r)
                ST_RST:     state_r <= ST_FETCH;
                ST_FETCH:   state_r <= imem_ready ? ST_DECODE : ST_FETCH;
                ST_DECODE:  state_r <= dispatch(opcode_s, funct3_s, funct7b5_s);
                ST_EXEC_R:  state_r <= ST_WB_ALU;
                ST_EXEC_I:  state_r <= ST_WB_ALU;
                ST_WB_ALU:  state_r <= ST_FETCH;
                ST_ADDR:    state_r <= is_store_s ? ST_MEM_WR : ST_MEM_RD;
                ST_MEM_RD:  state_r <= dmem_ready ? ST_WB_MEM : ST_MEM_RD;
                ST_WB_MEM:  state_r <= ST_FETCH;
                ST_MEM_WR:  state_r <= dmem_ready ? ST_FETCH : ST_MEM_WR;
                ST_BR_CMP:  state_r <= branch_taken(funct3_s, zero) ? ST_BR_TGT : ST_FETCH;
                ST_BR_TGT:  state_r <= ST_PC_JMP;
                ST_JMP_TGT: state_r <= ST_PC_JMP;
                ST_PC_JMP:  state_r <= ST_FETCH;
                ST_TRAP:    state_r <= ST_TRAP;
                default:    state_r <= ST_TRAP;
            endcase
        end
    end

    // Moore output decode, qualified by instr/zero/ready where a state needs them.
    always_comb begin
        pcsourse = 1'b0;
        pcwrite  = 1'b0;
        pccen    = 1'b0;
        irwrite  = 1'b0;
        regwen   = 1'b0;
        mdrwrite = 1'b0;
        wbsel    = WB_MDR;
        immsel   = IMM_J;
        asel     = A_REG;
        bsel     = B_REG;
        alusel   = ALU_ADD;
        dmem_re  = 1'b0;
        dmem_we  = 1'b0;
        retire   = 1'b0;
        illegal  = 1'b0;
        case (state_r)
            ST_FETCH: begin
                if (imem_ready) begin
                    irwrite = 1'b1;
                    pccen   = 1'b1;
                    pcwrite = 1'b1;
                end else begin
                    irwrite = 1'b0;
                end
            end
            ST_EXEC_R: begin
                alusel = alu_op(funct3_s, funct7b5_s);
            end
            ST_EXEC_I: begin
                bsel   = B_IMM;
                immsel = IMM_L;
                alusel = alu_op(funct3_s, 1'b0);
            end
            ST_WB_ALU: begin
                regwen = 1'b1;
                wbsel  = WB_ALUOUT;
                retire = 1'b1;
            end
            ST_ADDR: begin
                bsel   = B_IMM;
                immsel = is_store_s ? IMM_S : IMM_L;
            end
            // ALU inputs mirror ADDR so the data address stays stable while waiting.
            ST_MEM_RD: begin
                bsel     = B_IMM;
                immsel   = IMM_L;
                dmem_re  = 1'b1;
                mdrwrite = dmem_ready;
            end
            ST_MEM_WR: begin
                bsel    = B_IMM;
                immsel  = IMM_S;
                dmem_we = 1'b1;
                retire  = dmem_ready;
            end
            ST_WB_MEM: begin
                regwen = 1'b1;
                wbsel  = WB_MDR;
                retire = 1'b1;
            end
            ST_BR_CMP: begin
                alusel = branch_alu(funct3_s);
                retire = ~branch_taken(funct3_s, zero);
            end
            ST_BR_TGT: begin
                asel   = A_PCC;
                bsel   = B_IMM;
                immsel = IMM_B;
            end
            ST_JMP_TGT: begin
                regwen = 1'b1;
                wbsel  = WB_PC;
                bsel   = B_IMM;
                if (opcode_s == OPC_JAL) begin
                    asel   = A_PCC;
                    immsel = IMM_J;
                end else begin
                    asel   = A_REG;
                    immsel = IMM_L;
                end
            end
            ST_PC_JMP: begin
                pcwrite  = 1'b1;
                pcsourse = 1'b1;
                retire   = 1'b1;
            end
            ST_TRAP: begin
                illegal = 1'b1;
            end
            default: begin
                illegal = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_rv_ctl.sv
// Directed bench for rv_ctl: a per-instruction behavioural model builds the
// expected control vector for every cycle; one negedge process compares it.
module tb_rv_ctl;

    typedef struct packed {
        logic       pcsourse;
        logic       pcwrite;
        logic       pccen;
        logic       irwrite;
        logic       regwen;
        logic       mdrwrite;
        logic [1:0] wbsel;
        logic [1:0] immsel;
        logic [1:0] asel;
        logic [1:0] bsel;
        logic [3:0] alusel;
        logic       dmem_re;
        logic       dmem_we;
        logic       retire;
        logic       illegal;
    } ctl_t;

    typedef enum int {C_R, C_I, C_LD, C_ST, C_BR, C_JAL, C_JALR, C_TRAP} cls_t;

    // ALU code per funct3 for the non-alternate OP/OP-IMM operations
    localparam logic [3:0] R_TAB [8] = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};

    logic        clk, rst, zero, imem_ready, dmem_ready;
    logic [31:0] instr;
    logic        pcsourse, pcwrite, pccen, irwrite, regwen, mdrwrite;
    logic [1:0]  wbsel, immsel, asel, bsel;
    logic [3:0]  alusel;
    logic        dmem_re, dmem_we, retire, illegal;

    ctl_t  act, exp_ctl, last;
    ctl_t  hist[$];
    logic  exp_valid;
    string exp_name;
    int    checks, failures;
    int    n, ret_step, ret_cnt, re_cnt, mdr_cnt, pcw_cnt;

    rv_ctl #(.DPWIDTH(32)) dut (
        .clk(clk), .rst(rst), .instr(instr), .zero(zero),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .pcsourse(pcsourse), .pcwrite(pcwrite), .pccen(pccen), .irwrite(irwrite),
        .regwen(regwen), .mdrwrite(mdrwrite), .wbsel(wbsel), .immsel(immsel),
        .asel(asel), .bsel(bsel), .alusel(alusel), .dmem_re(dmem_re),
        .dmem_we(dmem_we), .retire(retire), .illegal(illegal)
    );

    assign act = {pcsourse, pcwrite, pccen, irwrite, regwen, mdrwrite, wbsel, immsel,
                  asel, bsel, alusel, dmem_re, dmem_we, retire, illegal};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Per-cycle comparison of the DUT against the model's expected vector
    always @(negedge clk) begin
        if (exp_valid) begin
            checks++;
            if (act !== exp_ctl) begin
                failures++;
                $display("FAIL %s t=%0t actual=%h expected=%h", exp_name, $time, act, exp_ctl);
            end
        end
    end

    task automatic check_lit(input string nm, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, got, want);
        end
    endtask

    task automatic step(input ctl_t e, input string nm);
        exp_ctl   = e;
        exp_name  = nm;
        exp_valid = 1'b1;
        @(negedge clk);
        last = act;
        hist.push_back(act);
        n++;
        if (act.retire)   begin ret_cnt++; ret_step = n; end
        if (act.dmem_re)  re_cnt++;
        if (act.mdrwrite) mdr_cnt++;
        if (act.pcwrite)  pcw_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        exp_ctl  = '0;
        exp_name = "reset";
        #1;
        check_lit("rst_outputs_zero", int'(act), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst        = 1'b0;
        imem_ready = 1'b1;
        step('0, "rst_state");
    endtask

    function automatic cls_t classify(input logic [31:0] ir);
        logic [2:0] f3;
        f3 = ir[14:12];
        case (ir[6:0])
            7'b0110011: return C_R;
            7'b0010011: return (f3 == 3'd5 && ir[30]) ? C_TRAP : C_I;
            7'b0000011: return (f3 == 3'd2) ? C_LD : C_TRAP;
            7'b0100011: return (f3 == 3'd2) ? C_ST : C_TRAP;
            7'b1100011: return (f3 == 3'd2 || f3 == 3'd3) ? C_TRAP : C_BR;
            7'b1101111: return C_JAL;
            7'b1100111: return (f3 == 3'd0) ? C_JALR : C_TRAP;
            default:    return C_TRAP;
        endcase
    endfunction

    function automatic ctl_t v_pcjmp();
        ctl_t e;
        e = '0; e.pcwrite = 1'b1; e.pcsourse = 1'b1; e.retire = 1'b1;
        return e;
    endfunction

    // Model: walk one instruction through its cycles, expecting spec-defined strobes
    task automatic exec(input logic [31:0] ir, input logic z, input int istall,
                        input int dstall, input int exp_lat, input string nm);
        ctl_t       e;
        cls_t       cls;
        logic [2:0] f3;
        logic       tk;
        f3  = ir[14:12];
        cls = classify(ir);
        hist.delete();
        n = 0; ret_step = 0; ret_cnt = 0; re_cnt = 0; mdr_cnt = 0; pcw_cnt = 0;
        instr = ir; zero = z; dmem_ready = 1'b0;
        for (int i = 0; i < istall; i++) begin
            imem_ready = 1'b0;
            step('0, {nm, "_fetch_wait"});
        end
        imem_ready = 1'b1;
        e = '0; e.irwrite = 1'b1; e.pccen = 1'b1; e.pcwrite = 1'b1;
        step(e, {nm, "_fetch"});
        imem_ready = 1'b0;
        step('0, {nm, "_decode"});
        e = '0;
        case (cls)
            C_R, C_I: begin
                e.alusel = R_TAB[f3];
                if (cls == C_R && ir[30] && f3 == 3'd0) e.alusel = 4'd1;
                if (cls == C_R && ir[30] && f3 == 3'd5) e.alusel = 4'd7;
                if (cls == C_I) begin e.bsel = 2'd1; e.immsel = 2'd3; end
                step(e, {nm, "_exec"});
                e = '0; e.regwen = 1'b1; e.wbsel = 2'd1; e.retire = 1'b1;
                step(e, {nm, "_wb_alu"});
            end
            C_LD, C_ST: begin
                e.bsel   = 2'd1;
                e.immsel = (cls == C_ST) ? 2'd2 : 2'd3;
                step(e, {nm, "_addr"});
                if (cls == C_ST) e.dmem_we = 1'b1;
                else             e.dmem_re = 1'b1;
                for (int i = 0; i < dstall; i++) begin
                    dmem_ready = 1'b0;
                    step(e, {nm, "_mem_wait"});
                end
                dmem_ready = 1'b1;
                if (cls == C_ST) e.retire = 1'b1;
                else             e.mdrwrite = 1'b1;
                step(e, {nm, "_mem_done"});
                dmem_ready = 1'b0;
                if (cls == C_LD) begin
                    e = '0; e.regwen = 1'b1; e.wbsel = 2'd0; e.retire = 1'b1;
                    step(e, {nm, "_wb_mem"});
                end
            end
            C_BR: begin
                case (f3)
                    3'd0:    begin e.alusel = 4'd1; tk = z;  end
                    3'd1:    begin e.alusel = 4'd1; tk = !z; end
                    3'd4:    begin e.alusel = 4'd3; tk = !z; end
                    3'd5:    begin e.alusel = 4'd3; tk = z;  end
                    3'd6:    begin e.alusel = 4'd4; tk = !z; end
                    default: begin e.alusel = 4'd4; tk = z;  end
                endcase
                e.retire = !tk;
                step(e, {nm, "_br_cmp"});
                if (tk) begin
                    e = '0; e.asel = 2'd1; e.bsel = 2'd1; e.immsel = 2'd1;
                    step(e, {nm, "_br_tgt"});
                    step(v_pcjmp(), {nm, "_pc_jmp"});
                end
            end
            C_JAL, C_JALR: begin
                e.regwen = 1'b1; e.wbsel = 2'd2; e.bsel = 2'd1;
                e.asel   = (cls == C_JAL) ? 2'd1 : 2'd0;
                e.immsel = (cls == C_JAL) ? 2'd0 : 2'd3;
                step(e, {nm, "_jmp_tgt"});
                step(v_pcjmp(), {nm, "_pc_jmp"});
            end
            default: begin
                e.illegal = 1'b1;
                for (int i = 0; i < 3; i++) begin
                    imem_ready = 1'b1; dmem_ready = 1'b1; zero = !zero;
                    step(e, {nm, "_trap"});
                end
            end
        endcase
        if (cls != C_TRAP) begin
            check_lit({nm, "_latency"}, ret_step, exp_lat);
            check_lit({nm, "_retire_count"}, ret_cnt, 1);
        end
    endtask

    initial begin
        ctl_t e;
        checks = 0; failures = 0; exp_valid = 1'b0; exp_name = "init";
        rst = 1'b1; zero = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0; instr = 32'h0;
        exp_ctl = '0; exp_valid = 1'b1; exp_name = "in_reset";
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0; imem_ready = 1'b1;
        step('0, "rst_state");

        exec(32'h00500093, 1'b0, 0, 0, 4, "addi");
        check_lit("addi_fetch_irwrite", int'(hist[0].irwrite), 1);
        check_lit("addi_fetch_pcwrite", int'(hist[0].pcwrite), 1);
        check_lit("addi_wb_regwen", int'(hist[3].regwen), 1);
        check_lit("addi_wb_wbsel", int'(hist[3].wbsel), 1);
        check_lit("addi_wb_alusel", int'(hist[3].alusel), 0);
        check_lit("addi_wb_retire", int'(hist[3].retire), 1);

        exec(32'h002081b3, 1'b0, 0, 0, 4, "add");
        check_lit("add_alusel", int'(hist[2].alusel), 0);
        exec(32'h402081b3, 1'b0, 0, 0, 4, "sub");
        check_lit("sub_alusel", int'(hist[2].alusel), 1);
        exec(32'h4020d1b3, 1'b0, 0, 0, 4, "sra");
        exec(32'h0020f1b3, 1'b0, 0, 0, 4, "and");
        exec(32'h0020b1b3, 1'b0, 0, 0, 4, "sltu");
        exec(32'hc0008093, 1'b0, 0, 0, 4, "addi_neg");
        check_lit("addi_neg_alusel", int'(hist[2].alusel), 0);
        exec(32'h0010d093, 1'b0, 0, 0, 4, "srli");

        exec(32'h0000a283, 1'b0, 0, 3, 8, "lw_stall");
        check_lit("lw_dmem_re_cycles", re_cnt, 4);
        check_lit("lw_mdrwrite_cycles", mdr_cnt, 1);
        check_lit("lw_mdrwrite_last", int'(hist[6].mdrwrite), 1);
        exec(32'h0000a283, 1'b0, 0, 0, 5, "lw");
        exec(32'h0050a223, 1'b0, 0, 0, 4, "sw");
        exec(32'h0050a223, 1'b0, 2, 1, 7, "sw_stall");

        exec(32'h00208463, 1'b1, 0, 0, 5, "beq_taken");
        check_lit("beq_tgt_asel", int'(hist[3].asel), 1);
        check_lit("beq_tgt_immsel", int'(hist[3].immsel), 1);
        check_lit("beq_pcjmp_pcsourse", int'(hist[4].pcsourse), 1);
        exec(32'h00209463, 1'b1, 0, 0, 3, "bne_not_taken");
        check_lit("bne_pcwrite_cycles", pcw_cnt, 1);
        exec(32'h0020c463, 1'b0, 0, 0, 5, "blt_taken");
        exec(32'h0020f463, 1'b0, 0, 0, 3, "bgeu_not_taken");

        exec(32'h010000ef, 1'b0, 0, 0, 4, "jal");
        check_lit("jal_wbsel", int'(hist[2].wbsel), 2);
        check_lit("jal_asel", int'(hist[2].asel), 1);
        exec(32'h000080e7, 1'b0, 0, 0, 4, "jalr");
        check_lit("jalr_immsel", int'(hist[2].immsel), 3);

        // Store aborted by reset while waiting in MEM_WR
        instr = 32'h0050a223; imem_ready = 1'b1; dmem_ready = 1'b0;
        e = '0; e.irwrite = 1'b1; e.pccen = 1'b1; e.pcwrite = 1'b1;
        step(e, "abort_fetch");
        imem_ready = 1'b0;
        step('0, "abort_decode");
        e = '0; e.bsel = 2'd1; e.immsel = 2'd2;
        step(e, "abort_addr");
        e.dmem_we = 1'b1;
        exp_ctl = e; exp_name = "abort_mem_wr";
        #1;
        check_lit("abort_we_before_rst", int'(dmem_we), 1);
        do_reset();
        exec(32'h00500093, 1'b0, 0, 0, 4, "addi_after_abort");

        exec(32'h4010d093, 1'b0, 0, 0, 0, "srai");
        check_lit("srai_illegal", int'(last.illegal), 1);
        do_reset();
        exec(32'h0020a463, 1'b0, 0, 0, 0, "bad_branch");
        check_lit("bad_branch_illegal", int'(last.illegal), 1);
        do_reset();
        exec(32'h002081b3, 1'b0, 0, 0, 4, "add_after_trap");

        exp_valid = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
